// File: rtl/mips32_boot_ctrl.sv
// Boot sequencer for the pipelined MIPS32 core.
// Loads a program into instruction memory, initialises and runs the core until
// HALT or timeout, then streams a register dump out over valid/ready.
module mips32_boot_ctrl #(
  parameter int IMEM_AW     = 10,
  parameter int DUMP_REGS   = 6,
  parameter int RUN_TIMEOUT = 1024
) (
  input  logic               clk1,
  input  logic               rst_n,
  input  logic               start,
  input  logic [IMEM_AW:0]   prog_len,
  input  logic               ld_valid,
  input  logic [31:0]        ld_data,
  output logic               ld_ready,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               core_init,
  output logic               core_run,
  input  logic               core_halted,
  output logic [4:0]         reg_raddr,
  input  logic [31:0]        reg_rdata,
  output logic               dump_valid,
  output logic [4:0]         dump_idx,
  output logic [31:0]        dump_data,
  input  logic               dump_ready,
  output logic               busy,
  output logic               done,
  output logic               timeout
);

  localparam int CW = $clog2(RUN_TIMEOUT);
  localparam logic [IMEM_AW:0] MAXLEN = {1'b1, {IMEM_AW{1'b0}}};
  localparam logic [CW-1:0]    TLAST  = CW'(RUN_TIMEOUT - 1);
  localparam logic [4:0]       DLAST  = 5'(DUMP_REGS - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_INIT, S_RUN, S_DUMP, S_DONE} state_t;

  state_t           state, nstate;
  logic [IMEM_AW:0] len, wcnt, plen_c;
  logic [CW-1:0]    ccnt;
  logic [4:0]       didx;
  logic             timeout_q;

  // start is only honoured when no sequence is in flight
  logic start_ok, ld_xfer, dump_xfer, halt_hit, tmo_hit;
  assign start_ok  = start && (state == S_IDLE || state == S_DONE);
  assign ld_xfer   = (state == S_LOAD) && ld_valid;
  assign dump_xfer = (state == S_DUMP) && dump_ready;
  assign halt_hit  = (state == S_RUN) && core_halted;
  // halt takes priority, so a timeout only counts when the core is still running
  assign tmo_hit   = (state == S_RUN) && !core_halted && (ccnt == TLAST);
  assign plen_c    = (prog_len > MAXLEN) ? MAXLEN : prog_len;

  // State register
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nstate;
  end

  // Next-state logic
  always_comb begin
    nstate = state;
    case (state)
      S_IDLE, S_DONE: if (start_ok) nstate = (plen_c != '0) ? S_LOAD : S_INIT;
      S_LOAD:         if (ld_xfer && (wcnt == len - 1'b1)) nstate = S_INIT;
      S_INIT:         nstate = S_RUN;
      S_RUN:          if (halt_hit || tmo_hit) nstate = S_DUMP;
      S_DUMP:         if (dump_xfer && (didx == DLAST)) nstate = S_DONE;
      default:        nstate = S_IDLE;
    endcase
  end

  // Counters, latched length and sticky timeout flag
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      len       <= '0;
      wcnt      <= '0;
      ccnt      <= '0;
      didx      <= '0;
      timeout_q <= 1'b0;
    end else if (start_ok) begin
      len       <= plen_c;
      wcnt      <= '0;
      ccnt      <= '0;
      didx      <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (ld_xfer) wcnt <= wcnt + 1'b1;
      // hold the cycle counter on the exit cycle so it never wraps
      if (state == S_RUN && !halt_hit && !tmo_hit) ccnt <= ccnt + 1'b1;
      if (tmo_hit) timeout_q <= 1'b1;
      if (dump_xfer && didx != DLAST) didx <= didx + 1'b1;
    end
  end

  // Outputs decoded from state; data paths are zeroed outside their phase
  always_comb begin
    ld_ready   = (state == S_LOAD);
    imem_we    = ld_xfer;
    imem_addr  = ld_xfer ? wcnt[IMEM_AW-1:0] : '0;
    imem_wdata = ld_xfer ? ld_data : '0;
    core_init  = (state == S_INIT);
    core_run   = (state == S_RUN);
    dump_valid = (state == S_DUMP);
    reg_raddr  = (state == S_DUMP) ? didx : '0;
    dump_idx   = reg_raddr;
    dump_data  = (state == S_DUMP) ? reg_rdata : '0;
    busy       = (state == S_LOAD) || (state == S_INIT) || (state == S_RUN) || (state == S_DUMP);
    done       = (state == S_DONE);
    timeout    = timeout_q;
  end

endmodule

// File: tb/tb_mips32_boot_ctrl.sv
// Directed bench for mips32_boot_ctrl with a tiny behavioural core
// (ADDI/ADD/OR/HLT, one instruction per enabled cycle) behind it.
module tb_mips32_boot_ctrl;
  localparam int AW = 4, NR = 6, RT = 16;

  logic clk1 = 0, rst_n = 0, start = 0, ld_valid = 0, dump_ready = 1;
  logic [AW:0] prog_len = '0;
  logic [31:0] ld_data = '0;
  logic ld_ready, imem_we, core_init, core_run, core_halted, dump_valid, busy, done, timeout;
  logic [AW-1:0] imem_addr;
  logic [31:0] imem_wdata, reg_rdata, dump_data;
  logic [4:0] reg_raddr, dump_idx;

  mips32_boot_ctrl #(.IMEM_AW(AW), .DUMP_REGS(NR), .RUN_TIMEOUT(RT)) dut (
    .clk1(clk1), .rst_n(rst_n), .start(start), .prog_len(prog_len),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_init(core_init), .core_run(core_run), .core_halted(core_halted),
    .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
    .dump_valid(dump_valid), .dump_idx(dump_idx), .dump_data(dump_data), .dump_ready(dump_ready),
    .busy(busy), .done(done), .timeout(timeout));

  always #5 clk1 = ~clk1;

  int ntests = 0, nfail = 0;

  // core model
  logic [31:0] imem [0:(1<<AW)-1];
  logic [31:0] rf [0:31];
  logic [AW-1:0] pc = '0;
  logic halted = 1'b0, nohalt = 1'b0;
  wire [31:0] cur = imem[pc];
  wire [5:0]  op  = cur[31:26];
  wire [4:0]  rs = cur[25:21], rt = cur[20:16], rd = cur[15:11];
  assign core_halted = halted;
  assign reg_rdata   = rf[reg_raddr];

  localparam logic [5:0] OP_ADD = 6'b000000, OP_OR = 6'b000011, OP_ADDI = 6'b001010, OP_HLT = 6'b111111;
  localparam logic [31:0] HLT = 32'hfc000000;
  function automatic logic [31:0] addi(input int t, input int s, input int imm);
    return {OP_ADDI, 5'(s), 5'(t), 16'(imm)};
  endfunction
  function automatic logic [31:0] rr(input logic [5:0] o, input int d, input int s, input int t);
    return {o, 5'(s), 5'(t), 5'(d), 11'd0};
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    for (int i = 0; i < (1<<AW); i++) imem[i] = '0;
  end

  always @(posedge clk1) begin
    if (imem_we) imem[imem_addr] <= imem_wdata;
    if (core_init) begin
      pc <= '0; halted <= 1'b0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (core_run && !halted) begin
      pc <= pc + 1'b1;
      case (op)
        OP_ADDI: if (rt != 0) rf[rt] <= rf[rs] + {{16{cur[15]}}, cur[15:0]};
        OP_ADD:  if (rd != 0) rf[rd] <= rf[rs] + rf[rt];
        OP_OR:   if (rd != 0) rf[rd] <= rf[rs] | rf[rt];
        OP_HLT:  if (!nohalt) halted <= 1'b1;
        default: ;
      endcase
    end
  end

  // monitors
  int cyc = 0, n_init = 0, n_run = 0;
  int wr_addr[$], wr_cyc[$], d_idx[$];
  logic [31:0] wr_data[$], d_data[$];
  always @(posedge clk1) begin
    cyc++;
    if (imem_we) begin wr_addr.push_back(int'(imem_addr)); wr_data.push_back(imem_wdata); wr_cyc.push_back(cyc); end
    if (core_init) n_init++;
    if (core_run) n_run++;
    if (dump_valid && dump_ready) begin d_idx.push_back(int'(dump_idx)); d_data.push_back(dump_data); end
  end

  wire [7:0] ctl = {ld_ready, imem_we, core_init, core_run, dump_valid, busy, done, timeout};
  wire any_data = |{imem_addr, imem_wdata, reg_raddr, dump_idx, dump_data};

  task automatic clr();
    wr_addr.delete(); wr_cyc.delete(); wr_data.delete(); d_idx.delete(); d_data.delete();
    n_init = 0; n_run = 0;
  endtask

  task automatic do_start(input int len);
    start = 1; prog_len = (AW+1)'(len);
    @(negedge clk1);
    start = 0;
  endtask

  task automatic send_word(input logic [31:0] w);
    int t = 0;
    ld_valid = 1; ld_data = w;
    while (!ld_ready && t < 50) begin @(negedge clk1); t++; end
    ntests++;
    if (!ld_ready) begin nfail++; $display("FAIL ld_ready_wait: ld_ready=%0b required 1", ld_ready); end
    @(negedge clk1);
    ld_valid = 0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 500) begin @(negedge clk1); t++; end
    ntests++;
    if (!done) begin nfail++; $display("FAIL wait_done: done=%0b required 1 within budget", done); end
  endtask

  task automatic test_reset();
    rst_n = 0;
    #22;
    ntests++;
    if (ctl !== 8'h00 || any_data !== 1'b0) begin
      nfail++; $display("FAIL reset_outputs: ctl=%b data_or=%b required 0", ctl, any_data);
    end
    @(negedge clk1); rst_n = 1;
    @(negedge clk1);
  endtask

  task automatic test_basic();
    logic [31:0] prog [9];
    logic [31:0] exp [6];
    prog = '{addi(1,0,10), addi(2,0,20), addi(3,0,25), rr(OP_OR,7,7,7), rr(OP_OR,7,7,7),
             rr(OP_ADD,4,1,2), rr(OP_OR,7,7,7), rr(OP_ADD,5,4,3), HLT};
    exp  = '{32'd0, 32'd10, 32'd20, 32'd25, 32'd30, 32'd55};
    clr();
    do_start(9);
    for (int i = 0; i < 9; i++) send_word(prog[i]);
    wait_done();
    ntests++;
    if (wr_addr.size() != 9) begin nfail++; $display("FAIL basic_wr_count: %0d required 9", wr_addr.size()); end
    else begin
      for (int i = 0; i < 9; i++) begin
        ntests++;
        if (wr_addr[i] != i || wr_data[i] !== prog[i]) begin
          nfail++; $display("FAIL basic_wr[%0d]: addr=%0d data=%h required addr=%0d data=%h", i, wr_addr[i], wr_data[i], i, prog[i]);
        end
      end
      ntests++;
      if (wr_cyc[8] - wr_cyc[0] != 8) begin nfail++; $display("FAIL basic_wr_span: %0d cycles required 8", wr_cyc[8]-wr_cyc[0]); end
    end
    ntests++;
    if (n_init != 1) begin nfail++; $display("FAIL basic_init_pulses: %0d required 1", n_init); end
    ntests++;
    if (d_idx.size() != NR) begin nfail++; $display("FAIL basic_dump_count: %0d required %0d", d_idx.size(), NR); end
    else for (int i = 0; i < NR; i++) begin
      ntests++;
      if (d_idx[i] != i || d_data[i] !== exp[i]) begin
        nfail++; $display("FAIL basic_dump[%0d]: idx=%0d data=%0d required idx=%0d data=%0d", i, d_idx[i], d_data[i], i, exp[i]);
      end
    end
    ntests++;
    if ({done, timeout, busy} !== 3'b100) begin nfail++; $display("FAIL basic_status: done/timeout/busy=%b required 100", {done, timeout, busy}); end
  endtask

  task automatic test_gapped_load();
    logic [31:0] prog [4];
    prog = '{addi(1,0,1), addi(2,0,2), rr(OP_ADD,3,1,2), HLT};
    clr();
    do_start(4);
    for (int i = 0; i < 4; i++) begin send_word(prog[i]); @(negedge clk1); end
    wait_done();
    ntests++;
    if (wr_addr.size() != 4) begin nfail++; $display("FAIL gap_wr_count: %0d required 4", wr_addr.size()); end
    else for (int i = 0; i < 4; i++) begin
      ntests++;
      if (wr_addr[i] != i || wr_data[i] !== prog[i]) begin
        nfail++; $display("FAIL gap_wr[%0d]: addr=%0d data=%h required addr=%0d data=%h", i, wr_addr[i], wr_data[i], i, prog[i]);
      end
    end
    ntests++;
    if (d_data.size() != NR || d_data[3] !== 32'd3) begin nfail++; $display("FAIL gap_dump_r3: size=%0d r3=%0d required size 6 r3=3", d_data.size(), d_data.size() > 3 ? d_data[3] : 0); end
  endtask

  task automatic test_timeout();
    nohalt = 1;
    clr();
    do_start(1);
    send_word(rr(OP_OR,7,7,7));
    wait_done();
    nohalt = 0;
    ntests++;
    if (n_run != RT) begin nfail++; $display("FAIL tmo_run_cycles: %0d required %0d", n_run, RT); end
    ntests++;
    if (timeout !== 1'b1) begin nfail++; $display("FAIL tmo_flag: %0b required 1", timeout); end
    ntests++;
    if (d_idx.size() != NR) begin nfail++; $display("FAIL tmo_dump_count: %0d required %0d", d_idx.size(), NR); end
  endtask

  task automatic test_dump_stall();
    int t = 0;
    clr();
    do_start(2);
    send_word(addi(2,0,77));
    send_word(HLT);
    while (!(dump_valid && dump_idx == 5'd2) && t < 200) begin @(negedge clk1); t++; end
    dump_ready = 0;
    repeat (3) begin
      @(negedge clk1);
      ntests++;
      if (dump_valid !== 1'b1 || dump_idx !== 5'd2 || dump_data !== 32'd77) begin
        nfail++; $display("FAIL stall_hold: valid=%0b idx=%0d data=%0d required 1/2/77", dump_valid, dump_idx, dump_data);
      end
    end
    dump_ready = 1;
    wait_done();
    ntests++;
    if (timeout !== 1'b0) begin nfail++; $display("FAIL stall_timeout_cleared: %0b required 0", timeout); end
    ntests++;
    if (d_idx.size() != NR) begin nfail++; $display("FAIL stall_dump_count: %0d required %0d", d_idx.size(), NR); end
    else for (int i = 0; i < NR; i++) begin
      ntests++;
      if (d_idx[i] != i) begin nfail++; $display("FAIL stall_seq[%0d]: idx=%0d required %0d", i, d_idx[i], i); end
    end
  endtask

  task automatic test_reset_mid_load();
    clr();
    do_start(8);
    for (int i = 0; i < 4; i++) send_word(addi(1,0,i));
    ld_valid = 1; ld_data = 32'hdeadbeef;
    #2 rst_n = 0;
    #1;
    ntests++;
    if (ctl !== 8'h00 || any_data !== 1'b0) begin
      nfail++; $display("FAIL midload_reset: ctl=%b data_or=%b required 0", ctl, any_data);
    end
    ld_valid = 0;
    @(negedge clk1); rst_n = 1;
    @(negedge clk1);
    clr();
    do_start(2);
    send_word(addi(1,0,5));
    send_word(HLT);
    wait_done();
    ntests++;
    if (wr_addr.size() != 2 || wr_addr[0] != 0 || wr_addr[1] != 1) begin
      nfail++; $display("FAIL midload_reload: count=%0d required writes to 0,1", wr_addr.size());
    end
    ntests++;
    if (d_data.size() != NR || d_data[1] !== 32'd5) begin nfail++; $display("FAIL midload_r1: r1 wrong, required 5"); end
  endtask

  task automatic test_edges();
    int t = 0;
    // zero-length program goes straight to INIT
    clr();
    do_start(0);
    ntests++;
    if (core_init !== 1'b1 || ld_ready !== 1'b0) begin
      nfail++; $display("FAIL zero_len_init: core_init=%0b ld_ready=%0b required 1/0", core_init, ld_ready);
    end
    wait_done();
    ntests++;
    if (wr_addr.size() != 0 || n_init != 1) begin nfail++; $display("FAIL zero_len_writes: writes=%0d inits=%0d required 0/1", wr_addr.size(), n_init); end
    // oversize length is clamped to memory depth
    clr();
    do_start((1<<AW) + 1);
    for (int i = 0; i < (1<<AW); i++) send_word(i == 3 ? HLT : rr(OP_OR,7,7,7));
    ntests++;
    if (ld_ready !== 1'b0) begin nfail++; $display("FAIL clamp_ready: ld_ready=%0b required 0", ld_ready); end
    while (!core_run && t < 50) begin @(negedge clk1); t++; end
    do_start(2);
    wait_done();
    ntests++;
    if (wr_addr.size() != (1<<AW) || wr_addr[wr_addr.size()-1] != (1<<AW)-1) begin
      nfail++; $display("FAIL clamp_writes: count=%0d required %0d ending at %0d", wr_addr.size(), 1<<AW, (1<<AW)-1);
    end
    ntests++;
    if (n_init != 1 || timeout !== 1'b0 || d_idx.size() != NR) begin
      nfail++; $display("FAIL start_in_run: inits=%0d timeout=%0b dumps=%0d required 1/0/%0d", n_init, timeout, d_idx.size(), NR);
    end
    repeat (3) @(negedge clk1);
    ntests++;
    if (done !== 1'b1) begin nfail++; $display("FAIL done_hold: done=%0b required 1", done); end
  endtask

  initial begin
    @(negedge clk1);
    test_reset();
    test_basic();
    test_gapped_load();
    test_timeout();
    test_dump_stall();
    test_reset_mid_load();
    test_edges();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
